// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch encodings: PC source select, fetch states, word size
package cpu_pkg;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_J   = 2'b10;
   localparam logic [1:0] PCSRC_JR  = 2'b11;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      BOOT     = 2'b00,
      RUN      = 2'b01,
      REDIRECT = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// rtl/fetch_skid_fifo.sv - 2-entry 64-bit skid buffer between fetch and decode
module fetch_skid_fifo (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_push,
   input  logic [63:0] i_data,
   input  logic        i_pop,
   input  logic        i_clear,
   output logic [63:0] o_head,
   output logic [1:0]  o_count,
   output logic        o_full,
   output logic        o_empty
);
   logic [63:0] r_mem [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_clear) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC owner, word fetch issue, redirect/flush handling
module fetch_redirect_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] PCNew,
   output logic        Instr_Req,
   output logic [31:0] Instr_Addr,
   input  logic [31:0] Instr_Data,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic [31:0] Instr_Out,
   output logic [31:0] PC_Plus_Four,
   output logic        Flush,
   output logic        Misaligned,
   output logic [15:0] Redirect_Count
);
   fetch_state_t r_state;
   fetch_state_t w_next_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_tag;
   logic         r_inflight;
   logic         r_flush;
   logic         r_misaligned;
   logic [15:0]  r_redirect_count;
   logic         w_redirect;
   logic         w_pop;
   logic         w_push;
   logic         w_issue;
   logic         w_full;
   logic         w_empty;
   logic [1:0]   w_count;
   logic [2:0]   w_used;
   logic [63:0]  w_head;

   assign w_redirect = (PCSrc != PCSRC_SEQ) && (r_state != BOOT);
   assign w_pop      = !w_empty && Out_Ready && !w_redirect;
   assign w_push     = r_inflight && !w_redirect;
   // Slots spoken for after this edge: buffered plus in flight, less the entry leaving now.
   assign w_used     = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

   always_comb begin
      w_next_state = r_state;
      w_issue      = 1'b0;
      case (r_state)
         BOOT:     w_next_state = RUN;
         RUN: begin
            if (w_redirect) begin
               w_next_state = REDIRECT;
            end else begin
               w_issue = (w_used < 3'(FIFO_DEPTH)) && !(w_full && !w_pop);
            end
         end
         REDIRECT: w_next_state = w_redirect ? REDIRECT : RUN;
         default:  w_next_state = BOOT;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= BOOT;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_pc             <= RESET_PC;
         r_tag            <= '0;
         r_inflight       <= 1'b0;
         r_flush          <= 1'b0;
         r_misaligned     <= 1'b0;
         r_redirect_count <= '0;
      end else begin
         r_flush <= w_redirect;
         if (w_redirect) begin
            r_pc       <= PCNew & ~32'h3;
            r_inflight <= 1'b0;
            if (r_redirect_count != 16'hFFFF) begin
               r_redirect_count <= r_redirect_count + 16'd1;
            end
            if (PCNew[1:0] != 2'b00) begin
               r_misaligned <= 1'b1;
            end
         end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
               r_pc  <= r_pc + 32'(WORD_BYTES);
               r_tag <= r_pc + 32'(WORD_BYTES);
            end
         end
      end
   end

   fetch_skid_fifo u_fifo (
      .i_clk   (Clock),
      .i_rst   (Reset),
      .i_push  (w_push),
      .i_data  ({Instr_Data, r_tag}),
      .i_pop   (w_pop),
      .i_clear (w_redirect),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign Instr_Req      = w_issue;
   assign Instr_Addr     = r_pc;
   assign Out_Valid      = !w_empty;
   assign Instr_Out      = w_head[63:32];
   assign PC_Plus_Four   = w_head[31:0];
   assign Flush          = r_flush;
   assign Misaligned     = r_misaligned;
   assign Redirect_Count = r_redirect_count;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - scoreboard bench for fetch_redirect_unit
module tb_fetch_redirect_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [1:0]  PCSrc = 2'b00;
   logic [31:0] PCNew = '0;
   logic [31:0] Instr_Data = '0;
   logic        Out_Ready = 1'b0;
   logic        Instr_Req;
   logic [31:0] Instr_Addr;
   logic        Out_Valid;
   logic [31:0] Instr_Out;
   logic [31:0] PC_Plus_Four;
   logic        Flush;
   logic        Misaligned;
   logic [15:0] Redirect_Count;

   fetch_redirect_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .PCSrc          (PCSrc),
      .PCNew          (PCNew),
      .Instr_Req      (Instr_Req),
      .Instr_Addr     (Instr_Addr),
      .Instr_Data     (Instr_Data),
      .Out_Valid      (Out_Valid),
      .Out_Ready      (Out_Ready),
      .Instr_Out      (Instr_Out),
      .PC_Plus_Four   (PC_Plus_Four),
      .Flush          (Flush),
      .Misaligned     (Misaligned),
      .Redirect_Count (Redirect_Count)
   );

   always #5 Clock = ~Clock;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] sb_q [$];
   logic        s_req = 1'b0;
   logic [31:0] s_addr = '0;
   logic        drv_prev_rst = 1'b1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected delivery order: consecutive words from the stream start, wrapping at 2^32.
   task automatic refill(input logic [31:0] start);
      sb_q.delete();
      for (int i = 0; i < 256; i++) begin
         sb_q.push_back(start + 32'(i * 4));
      end
   endtask

   task automatic step(input logic rst, input logic [1:0] src, input logic [31:0] tgt, input logic rdy);
      @(posedge Clock);
      #1;
      Instr_Data = s_req ? mem_word(s_addr) : $urandom;
      Reset      = rst;
      PCSrc      = src;
      PCNew      = tgt;
      Out_Ready  = rdy;
      if (rst) begin
         refill(RST_PC);
      end else if (src != 2'b00 && !drv_prev_rst) begin
         refill(tgt & ~32'h3);
      end
      drv_prev_rst = rst;
   endtask

   logic        m_prev_rst = 1'b1;
   logic        m_exp_flush = 1'b0;
   logic        m_exp_mis = 1'b0;
   logic [15:0] m_exp_cnt = '0;
   logic        m_prev_acc = 1'b0;
   logic        m_prev_pop = 1'b0;
   logic        m_hold = 1'b0;
   logic [31:0] m_hold_i = '0;
   logic [31:0] m_hold_p = '0;
   logic        m_lat_arm = 1'b0;
   int          m_lat_n = 0;
   int          m_lat_req = 3;

   always @(negedge Clock) begin
      logic        acc;
      logic        boot;
      logic        pop;
      logic [31:0] e;
      s_req  = Instr_Req;
      s_addr = Instr_Addr;
      if (Reset) begin
         check("rst_valid", 32'(Out_Valid), 32'd0);
         check("rst_req", 32'(Instr_Req), 32'd0);
         check("rst_flush", 32'(Flush), 32'd0);
         check("rst_misaligned", 32'(Misaligned), 32'd0);
         check("rst_count", 32'(Redirect_Count), 32'd0);
         check("rst_instr_out", Instr_Out, 32'd0);
         check("rst_pc_plus_four", PC_Plus_Four, 32'd0);
         m_exp_flush = 1'b0;
         m_exp_mis   = 1'b0;
         m_exp_cnt   = '0;
         m_prev_acc  = 1'b0;
         m_prev_pop  = 1'b0;
         m_hold      = 1'b0;
         m_lat_arm   = 1'b1;
         m_lat_n     = -1;
         m_lat_req   = 3;
         m_prev_rst  = 1'b1;
      end else begin
         boot = m_prev_rst;
         acc  = !boot && (PCSrc != 2'b00);
         check("flush", 32'(Flush), 32'(m_exp_flush));
         check("redirect_count", 32'(Redirect_Count), 32'(m_exp_cnt));
         check("misaligned", 32'(Misaligned), 32'(m_exp_mis));
         if (boot || acc || m_prev_acc) check("bubble_no_req", 32'(Instr_Req), 32'd0);
         if (Instr_Req) check("addr_align", 32'(Instr_Addr[1:0]), 32'd0);
         if (m_prev_pop) check("sustained_valid", 32'(Out_Valid), 32'd1);
         if (m_hold) begin
            check("hold_valid", 32'(Out_Valid), 32'd1);
            check("hold_instr", Instr_Out, m_hold_i);
            check("hold_pc_plus_four", PC_Plus_Four, m_hold_p);
         end
         if (m_lat_arm) begin
            m_lat_n++;
            if (Out_Valid) begin
               check("first_valid_latency", 32'(m_lat_n), 32'(m_lat_req));
               m_lat_arm = 1'b0;
            end else if (m_lat_n > 8) begin
               check("first_valid_timeout", 32'(m_lat_n), 32'(m_lat_req));
               m_lat_arm = 1'b0;
            end
         end
         pop = Out_Valid && Out_Ready && !acc;
         if (pop) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_empty: got instr %h pc4 %h expected no delivery", Instr_Out, PC_Plus_Four);
            end else begin
               e = sb_q.pop_front();
               check("instr_out", Instr_Out, mem_word(e));
               check("pc_plus_four", PC_Plus_Four, e + 32'd4);
            end
         end
         m_hold      = Out_Valid && !Out_Ready && !acc;
         m_hold_i    = Instr_Out;
         m_hold_p    = PC_Plus_Four;
         m_prev_pop  = pop;
         m_exp_flush = acc;
         if (acc) begin
            if (m_exp_cnt != 16'hFFFF) m_exp_cnt = m_exp_cnt + 16'd1;
            if (PCNew[1:0] != 2'b00) m_exp_mis = 1'b1;
            m_lat_arm = 1'b1;
            m_lat_n   = 0;
            m_lat_req = 4;
         end
         m_prev_acc = acc;
         m_prev_rst = 1'b0;
      end
   end

   initial begin
      int          r;
      logic [31:0] tgt;
      logic        rdy;
      repeat (3) step(1'b1, 2'b00, 32'h0, 1'b1);
      step(1'b0, 2'b01, 32'h80, 1'b1);
      repeat (8) step(1'b0, 2'b00, 32'h0, 1'b1);
      repeat (5) step(1'b0, 2'b00, 32'h0, 1'b0);
      #2;
      check("stall_no_req", 32'(Instr_Req), 32'd0);
      check("stall_valid", 32'(Out_Valid), 32'd1);
      repeat (6) step(1'b0, 2'b00, 32'h0, 1'b1);
      step(1'b0, 2'b00, 32'h0, 1'b0);
      step(1'b0, 2'b01, 32'h40, 1'b0);
      repeat (8) step(1'b0, 2'b00, 32'h0, 1'b1);
      step(1'b0, 2'b10, 32'h102, 1'b1);
      repeat (6) step(1'b0, 2'b00, 32'h0, 1'b1);
      step(1'b0, 2'b11, 32'h200, 1'b1);
      step(1'b0, 2'b01, 32'h300, 1'b0);
      repeat (6) step(1'b0, 2'b00, 32'h0, 1'b1);
      step(1'b0, 2'b01, 32'hFFFF_FFF4, 1'b1);
      repeat (10) step(1'b0, 2'b00, 32'h0, 1'b1);
      step(1'b0, 2'b10, 32'h20, 1'b1);
      repeat (4) step(1'b0, 2'b00, 32'h0, 1'b1);
      step(1'b1, 2'b00, 32'h0, 1'b1);
      #1;
      check("async_rst_valid", 32'(Out_Valid), 32'd0);
      check("async_rst_req", 32'(Instr_Req), 32'd0);
      check("async_rst_count", 32'(Redirect_Count), 32'd0);
      step(1'b1, 2'b00, 32'h0, 1'b1);
      repeat (8) step(1'b0, 2'b00, 32'h0, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         r   = int'($urandom_range(0, 999));
         rdy = ($urandom_range(0, 9) < 7);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         if (r < 3) begin
            step(1'b1, 2'b00, 32'h0, rdy);
         end else if (r < 60) begin
            step(1'b0, 2'($urandom_range(1, 3)), tgt, rdy);
         end else begin
            step(1'b0, 2'b00, $urandom, rdy);
         end
      end
      repeat (4) step(1'b0, 2'b00, 32'h0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
